// File: rtl/hazard_tracker.sv
// Stall/forward decision logic for a 5-stage pipeline, tracking in-flight writers in E, M and W.
// Optional multdiv busy tracking is compiled in when HAZARD_TRACKER_MD_EN is defined.
module hazard_tracker #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NSRC   = 2,
  parameter int unsigned MD_LAT = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     d_valid,
  input  logic [NSRC*ADDR_W-1:0]   d_src_addr,
  input  logic [NSRC*2-1:0]        d_src_tuse,
  input  logic                     d_regwrite,
  input  logic [ADDR_W-1:0]        d_dst_addr,
  input  logic [1:0]               d_dst_tnew,
  input  logic                     d_md_start,
  input  logic                     d_md_use,
  output logic                     stall,
  output logic [NSRC*2-1:0]        fwd_sel,
  output logic                     md_busy
);

  localparam int unsigned TW    = 2;
  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [TW-1:0]     tnew;
  } rec_t;

  rec_t e_q, m_q, w_q;
  rec_t e_d, m_d, w_d;
  rec_t d_rec;
  logic hz_stall;
  logic md_stall;

  always_comb begin
    d_rec       = '0;
    d_rec.valid = d_valid && d_regwrite && (d_dst_addr != '0);
    d_rec.addr  = d_dst_addr;
    d_rec.tnew  = d_dst_tnew;
  end

  // Per-channel nearest-writer search; a younger match always shadows older ones.
  always_comb begin
    hz_stall = 1'b0;
    fwd_sel  = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      logic [ADDR_W-1:0] src;
      logic [TW-1:0]     tuse;
      logic [TW-1:0]     near_tnew;
      logic [TW-1:0]     near_sel;
      logic              live;
      src       = d_src_addr[i*ADDR_W +: ADDR_W];
      tuse      = d_src_tuse[i*TW +: TW];
      live      = (src != '0) && (tuse != 2'd3);
      near_sel  = 2'd0;
      near_tnew = 2'd0;
      if (live && e_q.valid && (e_q.addr == src)) begin
        near_sel  = 2'd1;
        near_tnew = e_q.tnew;
      end else if (live && m_q.valid && (m_q.addr == src)) begin
        near_sel  = 2'd2;
        near_tnew = m_q.tnew;
      end else if (live && w_q.valid && (w_q.addr == src)) begin
        near_sel  = 2'd3;
        near_tnew = w_q.tnew;
      end
      if (near_sel != 2'd0) begin
        if (near_tnew > tuse) begin
          hz_stall = hz_stall | d_valid;
        end
        if (near_tnew == 2'd0) begin
          fwd_sel[i*TW +: TW] = near_sel;
        end
      end
    end
  end

  assign stall = !reset && (hz_stall || md_stall);

  always_comb begin
    w_d      = m_q;
    m_d      = e_q;
    m_d.tnew = (e_q.tnew != '0) ? e_q.tnew - TW'(1) : '0;
    e_d      = stall ? '0 : d_rec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

`ifdef HAZARD_TRACKER_MD_EN
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

  // A start only loads when it actually issues; a start while busy is held by md_stall.
  always_comb begin
    md_cnt_d = (md_cnt_q != '0) ? md_cnt_q - CNT_W'(1) : '0;
    if (d_valid && d_md_start && !stall) begin
      md_cnt_d = CNT_W'(MD_LAT);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  assign md_busy  = (md_cnt_q != '0);
  assign md_stall = d_valid && d_md_use && md_busy;
`else
  logic unused_md;

  assign unused_md = d_md_start ^ d_md_use ^ (MD_LAT == 0) ^ (CNT_W == 0);
  assign md_busy   = 1'b0;
  assign md_stall  = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// Self-checking bench for hazard_tracker: directed scenarios plus randomized traffic against a reference model.
// Define HAZARD_TRACKER_MD_EN for both files to exercise the multdiv path.
module tb_hazard_tracker;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NSRC   = 2;
  localparam int unsigned MD_LAT = 5;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   d_valid;
  logic [NSRC*ADDR_W-1:0] d_src_addr;
  logic [NSRC*2-1:0]      d_src_tuse;
  logic                   d_regwrite;
  logic [ADDR_W-1:0]      d_dst_addr;
  logic [1:0]             d_dst_tnew;
  logic                   d_md_start;
  logic                   d_md_use;
  logic                   stall;
  logic [NSRC*2-1:0]      fwd_sel;
  logic                   md_busy;

  int errors = 0;
  int checks = 0;

  // Reference model: slot 0 = E, 1 = M, 2 = W
  logic              mv [3];
  logic [ADDR_W-1:0] ma [3];
  logic [1:0]        mt [3];
  int unsigned       mcnt;
  logic              exp_stall;
  logic [NSRC*2-1:0] exp_fwd;
  logic              exp_busy;
  logic              obs_stall;
  logic [NSRC*2-1:0] obs_fwd;
  logic              obs_busy;

  hazard_tracker #(.ADDR_W(ADDR_W), .NSRC(NSRC), .MD_LAT(MD_LAT)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_src_addr(d_src_addr),
    .d_src_tuse(d_src_tuse), .d_regwrite(d_regwrite), .d_dst_addr(d_dst_addr),
    .d_dst_tnew(d_dst_tnew), .d_md_start(d_md_start), .d_md_use(d_md_use),
    .stall(stall), .fwd_sel(fwd_sel), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int s = 0; s < 3; s++) begin
      mv[s] = 1'b0; ma[s] = '0; mt[s] = '0;
    end
    mcnt = 0;
  endfunction

  function automatic void model_eval();
    logic [ADDR_W-1:0] src;
    logic [1:0]        tuse;
    exp_stall = 1'b0;
    exp_fwd   = '0;
    for (int ch = 0; ch < NSRC; ch++) begin
      src  = d_src_addr[ch*ADDR_W +: ADDR_W];
      tuse = d_src_tuse[ch*2 +: 2];
      if (src == '0 || tuse == 2'd3) continue;
      for (int s = 0; s < 3; s++) begin
        if (mv[s] && ma[s] == src) begin
          if (mt[s] > tuse && d_valid) exp_stall = 1'b1;
          if (mt[s] == 2'd0) exp_fwd[ch*2 +: 2] = 2'(s + 1);
          break;
        end
      end
    end
    exp_busy = (mcnt != 0);
    if (d_valid && d_md_use && exp_busy) exp_stall = 1'b1;
  endfunction

  function automatic void model_advance();
    mv[2] = mv[1]; ma[2] = ma[1]; mt[2] = mt[1];
    mv[1] = mv[0]; ma[1] = ma[0]; mt[1] = (mt[0] > 0) ? mt[0] - 2'd1 : 2'd0;
    mv[0] = !exp_stall && d_valid && d_regwrite && (d_dst_addr != 0);
    ma[0] = d_dst_addr;
    mt[0] = d_dst_tnew;
`ifdef HAZARD_TRACKER_MD_EN
    if (d_valid && d_md_start && !exp_stall) mcnt = MD_LAT;
    else if (mcnt > 0) mcnt = mcnt - 1;
`endif
  endfunction

  task automatic drive(input logic v, input logic [4:0] s0, input logic [1:0] u0,
                       input logic [4:0] s1, input logic [1:0] u1, input logic rw,
                       input logic [4:0] dst, input logic [1:0] tn, input logic ms, input logic mu);
    d_valid = v; d_src_addr = {s1, s0}; d_src_tuse = {u1, u0};
    d_regwrite = rw; d_dst_addr = dst; d_dst_tnew = tn; d_md_start = ms; d_md_use = mu;
  endtask

  // Samples outputs mid-cycle, then advances the model across the rising edge.
  task automatic run_cycle();
    model_eval();
    @(negedge clk);
    obs_stall = stall; obs_fwd = fwd_sel; obs_busy = md_busy;
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic flush();
    drive(0, 0, 3, 0, 3, 0, 0, 0, 0, 0);
    repeat (MD_LAT + 4) run_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1, 3, 0, 4, 1, 1, 3, 2, 1, 1);
    repeat (2) begin
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", stall); end
      checks++; if (fwd_sel !== 4'b0) begin errors++; $display("FAIL reset_fwd: got %0h want 0", fwd_sel); end
      checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", md_busy); end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    flush();
  endtask

  task automatic test_load_use();
    drive(1, 0, 3, 0, 3, 1, 1, 2, 0, 0);   // lw $1
    run_cycle();
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL lw_issue_stall: got %0b want 0", obs_stall); end
    drive(1, 1, 1, 0, 3, 1, 4, 0, 0, 0);   // add $4, $1
    run_cycle();
    checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL load_use_stall: got %0b want 1", obs_stall); end
    run_cycle();
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL load_use_release: got %0b want 0", obs_stall); end
    checks++; if (obs_fwd[1:0] !== 2'd0) begin errors++; $display("FAIL load_use_fwd: got %0d want 0", obs_fwd[1:0]); end
    flush();
  endtask

  task automatic test_branch();
    drive(1, 0, 3, 0, 3, 1, 2, 1, 0, 0);   // ori $2
    run_cycle();
    drive(1, 2, 0, 0, 3, 0, 0, 0, 0, 0);   // beq $2
    run_cycle();
    checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL branch_stall: got %0b want 1", obs_stall); end
    checks++; if (obs_fwd[1:0] !== 2'd0) begin errors++; $display("FAIL branch_fwd_early: got %0d want 0", obs_fwd[1:0]); end
    run_cycle();
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL branch_release: got %0b want 0", obs_stall); end
    checks++; if (obs_fwd[1:0] !== 2'd2) begin errors++; $display("FAIL branch_fwd_m: got %0d want 2", obs_fwd[1:0]); end
    flush();
  endtask

  task automatic test_zero_reg();
    drive(1, 0, 3, 0, 3, 1, 0, 1, 0, 0);   // addu $0
    run_cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // beq $0, $0
    repeat (2) begin
      run_cycle();
      checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL zero_reg_stall: got %0b want 0", obs_stall); end
      checks++; if (obs_fwd !== 4'b0) begin errors++; $display("FAIL zero_reg_fwd: got %0h want 0", obs_fwd); end
    end
    flush();
  endtask

  task automatic test_nearest();
    drive(1, 0, 3, 0, 3, 1, 3, 0, 0, 0); run_cycle();   // lui $3
    drive(1, 0, 3, 0, 3, 1, 3, 0, 0, 0); run_cycle();   // lui $3
    drive(1, 5, 1, 3, 2, 0, 0, 0, 0, 0); run_cycle();   // sw $3
    checks++; if (obs_fwd[3:2] !== 2'd1) begin errors++; $display("FAIL nearest_fwd_e: got %0d want 1", obs_fwd[3:2]); end
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL nearest_stall_a: got %0b want 0", obs_stall); end
    flush();
    drive(1, 0, 3, 0, 3, 1, 3, 0, 0, 0); run_cycle();   // lui $3, tnew 0
    drive(1, 0, 3, 0, 3, 1, 3, 1, 0, 0); run_cycle();   // writer of $3, tnew 1
    drive(1, 5, 1, 3, 2, 0, 0, 0, 0, 0); run_cycle();   // sw $3
    checks++; if (obs_fwd[3:2] !== 2'd0) begin errors++; $display("FAIL nearest_no_older: got %0d want 0", obs_fwd[3:2]); end
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL nearest_stall_b: got %0b want 0", obs_stall); end
    flush();
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 3, 0, 3, 1, 9, 2, 0, 0); run_cycle();   // lw $9
    drive(1, 9, 0, 9, 1, 0, 0, 0, 0, 0);                // beq $9, $9
    #2;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mid_pre_stall: got %0b want 1", stall); end
    reset = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_reset_stall: got %0b want 0", stall); end
    checks++; if (fwd_sel !== 4'b0) begin errors++; $display("FAIL mid_reset_fwd: got %0h want 0", fwd_sel); end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    run_cycle();
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL mid_after_stall: got %0b want 0", obs_stall); end
    checks++; if (obs_fwd !== 4'b0) begin errors++; $display("FAIL mid_after_fwd: got %0h want 0", obs_fwd); end
    flush();
  endtask

  task automatic test_md();
`ifdef HAZARD_TRACKER_MD_EN
    drive(1, 4, 1, 5, 1, 0, 0, 0, 1, 1); run_cycle();   // mult
    checks++; if (obs_stall !== 1'b0 || obs_busy !== 1'b0) begin errors++; $display("FAIL md_start: stall %0b busy %0b want 0 0", obs_stall, obs_busy); end
    drive(1, 0, 3, 0, 3, 1, 8, 0, 0, 1);                // mflo $8
    for (int k = 0; k < MD_LAT; k++) begin
      run_cycle();
      checks++; if (obs_stall !== 1'b1 || obs_busy !== 1'b1) begin errors++; $display("FAIL md_busy_cycle%0d: stall %0b busy %0b want 1 1", k, obs_stall, obs_busy); end
    end
    run_cycle();
    checks++; if (obs_stall !== 1'b0 || obs_busy !== 1'b0) begin errors++; $display("FAIL md_done: stall %0b busy %0b want 0 0", obs_stall, obs_busy); end
    flush();
    drive(1, 0, 3, 0, 3, 1, 9, 2, 0, 0); run_cycle();   // lw $9
    drive(1, 4, 1, 5, 1, 0, 0, 0, 1, 1); run_cycle();   // mult
    drive(1, 0, 3, 0, 3, 1, 8, 0, 0, 1); run_cycle();   // mflo, first stalled cycle
    #2;
    reset = 1'b1;
    #1;
    checks++; if (stall !== 1'b0 || md_busy !== 1'b0) begin errors++; $display("FAIL md_reset: stall %0b busy %0b want 0 0", stall, md_busy); end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    drive(1, 9, 0, 8, 0, 0, 0, 0, 0, 0); run_cycle();
    checks++; if (obs_stall !== 1'b0 || obs_fwd !== 4'b0) begin errors++; $display("FAIL md_reset_records: stall %0b fwd %0h want 0 0", obs_stall, obs_fwd); end
`else
    drive(1, 4, 1, 5, 1, 0, 0, 0, 1, 1); run_cycle();
    drive(1, 0, 3, 0, 3, 1, 8, 0, 0, 1);
    repeat (3) begin
      run_cycle();
      checks++; if (obs_stall !== 1'b0 || obs_busy !== 1'b0) begin errors++; $display("FAIL md_disabled: stall %0b busy %0b want 0 0", obs_stall, obs_busy); end
    end
`endif
    flush();
  endtask

  task automatic test_random();
    logic hold;
    hold = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!hold) begin
        logic ms;
        ms = ($urandom_range(0, 7) == 0);
        drive($urandom_range(0, 3) != 0,
              5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
              ms, ms | ($urandom_range(0, 5) == 0));
      end
      run_cycle();
      checks++; if (obs_stall !== exp_stall) begin errors++; $display("FAIL rand_stall@%0d: got %0b want %0b", n, obs_stall, exp_stall); end
      checks++; if (obs_fwd !== exp_fwd) begin errors++; $display("FAIL rand_fwd@%0d: got %0h want %0h", n, obs_fwd, exp_fwd); end
      checks++; if (obs_busy !== exp_busy) begin errors++; $display("FAIL rand_busy@%0d: got %0b want %0b", n, obs_busy, exp_busy); end
      hold = exp_stall;
    end
    flush();
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 3, 0, 3, 1, 6, 1, 0, 0); run_cycle();   // writer $6, tnew 1
    drive(1, 0, 3, 0, 3, 1, 7, 2, 0, 0); run_cycle();   // writer $7, tnew 2
    drive(1, 6, 1, 7, 1, 0, 0, 0, 0, 0); run_cycle();   // reads $6 (M, ready) and $7 (E, late)
    checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL b2b_stall: got %0b want 1", obs_stall); end
    checks++; if (obs_fwd !== 4'b0010) begin errors++; $display("FAIL b2b_fwd: got %0h want 2", obs_fwd); end
    run_cycle();
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL b2b_release: got %0b want 0", obs_stall); end
    checks++; if (obs_fwd !== 4'b0011) begin errors++; $display("FAIL b2b_fwd_w: got %0h want 3", obs_fwd); end
    flush();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_branch();
    test_zero_reg();
    test_nearest();
    test_back_to_back();
    test_reset_mid();
    test_md();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
